// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_pkg
// Description : Shared definitions for the float-unit arbiter. Holds the
//               operation encodings, the arbiter FSM state encoding and
//               a small op-decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package float_pkg;

    typedef logic [1:0] fop_t;

    localparam fop_t FOP_ADD  = 2'd0;
    localparam fop_t FOP_SUB  = 2'd1;
    localparam fop_t FOP_CONV = 2'd2;
    localparam fop_t FOP_RSVD = 2'd3;

    // Width of the latency down-counter; LATENCY is limited to 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // True for operations that run on the shared FloatingAdd unit.
    function automatic logic usesAdder(input fop_t op);
        return (op == FOP_ADD) || (op == FOP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : float_arbiter_if
// Description : Bundle of the two requester channels, the shared float-unit
//               operand/enable/result signals and the response channel.
//               slave  : seen by float_arbiter
//               master : seen by the requesters / float units / consumer
// Revision    : 1.0  initial release
// ============================================================================
interface float_arbiter_if;
    import float_pkg::*;

    // Requester 0
    logic        req0_valid;
    fop_t        req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    // Requester 1
    logic        req1_valid;
    fop_t        req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    // Shared float units
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic        fu_add_en;
    logic        fu_sub;
    logic        fu_conv_en;
    logic [31:0] fu_add_result;
    logic [31:0] fu_conv_result;
    // Response channel
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    // Status
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  fu_add_result, fu_conv_result, rsp_ready,
        output req0_ready, req1_ready,
        output fu_a, fu_b, fu_add_en, fu_sub, fu_conv_en,
        output rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output fu_add_result, fu_conv_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  fu_a, fu_b, fu_add_en, fu_sub, fu_conv_en,
        input  rsp_valid, rsp_id, rsp_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant. A lone valid requester wins; on a
//               tie the requester that was not granted last wins.
// Ports       : i_valid0/i_valid1 request valids, i_lastGrant index of the
//               previous winner, o_grant one-hot grant (bit N = requester N).
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic       i_valid0,
    input  wire logic       i_valid1,
    input  wire logic       i_lastGrant,
    output logic [1:0]      o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = i_lastGrant ? 2'b01 : 2'b10;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/float_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : float_arbiter
// Description : Shares one FloatingAdd and one FloatingFromInt unit between two
//               requesters. One operation is in flight at a time:
//               IDLE -> ISSUE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
// Ports       : clk, reset (sync, active high)
//               bus (float_arbiter_if.slave): req0/req1 valid/op/a/b/ready,
//               fu_a/fu_b/fu_add_en/fu_sub/fu_conv_en and unit results,
//               rsp_valid/rsp_id/rsp_data/rsp_ready, busy.
// Params      : LATENCY 1..15, cycles from unit enable to valid unit result.
// Revision    : 1.0  initial release
// ============================================================================
module float_arbiter
    import float_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  wire logic       clk,
    input  wire logic       reset,
    float_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic               r_addEn;
    logic               w_addEnNext;
    logic               r_convEn;
    logic               w_convEnNext;
    logic               r_sub;
    logic               w_subNext;
    logic               w_capture;
    logic               w_rspDone;

    logic               r_lastGrant;
    logic [1:0]         w_grant;
    logic               w_xfer;
    logic               w_winId;
    fop_t               w_winOp;
    logic [31:0]        w_winA;
    logic [31:0]        w_winB;

    fop_t               r_op;
    logic               r_id;
    logic [31:0]        r_fuA;
    logic [31:0]        r_fuB;
    logic               r_rspValid;
    logic               r_rspId;
    logic [31:0]        r_rspData;
    logic [31:0]        w_result;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    rr_arbiter2 u_rrArbiter (
        .i_valid0    (bus.req0_valid),
        .i_valid1    (bus.req1_valid),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant)
    );

    // The arbiter only grants valid requesters, so ready already implies
    // valid and a ready in IDLE is a transfer.
    assign bus.req0_ready = (r_state == IDLE) && w_grant[0];
    assign bus.req1_ready = (r_state == IDLE) && w_grant[1];
    assign w_xfer         = (r_state == IDLE) && (w_grant != 2'b00);

    assign w_winId = w_grant[1];
    assign w_winOp = w_winId ? bus.req1_op : bus.req0_op;
    assign w_winA  = w_winId ? bus.req1_a  : bus.req0_a;
    assign w_winB  = w_winId ? bus.req1_b  : bus.req0_b;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addEn  <= 1'b0;
            r_convEn <= 1'b0;
            r_sub    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_addEn  <= w_addEnNext;
            r_convEn <= w_convEnNext;
            r_sub    <= w_subNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_addEnNext  = r_addEn;
        w_convEnNext = r_convEn;
        w_subNext    = r_sub;
        w_capture    = 1'b0;
        w_rspDone    = 1'b0;

        case (r_state)
            IDLE: begin
                // Enables are registered, so they are set on the transfer
                // edge in order to be high for the whole ISSUE cycle.
                if (w_xfer) begin
                    w_stateNext  = ISSUE;
                    w_addEnNext  = usesAdder(w_winOp);
                    w_subNext    = (w_winOp == FOP_SUB);
                    w_convEnNext = (w_winOp == FOP_CONV);
                end
            end
            ISSUE: begin
                w_cntNext   = c_CNT_LOAD;
                w_stateNext = WAIT;
            end
            WAIT: begin
                // LATENCY cycles in WAIT; the unit result is valid in the
                // last of them and is captured on the edge leaving WAIT.
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_stateNext  = RESP;
                    w_addEnNext  = 1'b0;
                    w_convEnNext = 1'b0;
                    w_subNext    = 1'b0;
                end else begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rspDone   = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext  = IDLE;
                w_cntNext    = '0;
                w_addEnNext  = 1'b0;
                w_convEnNext = 1'b0;
                w_subNext    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result select for the operation in flight
    // ------------------------------------------------------------------
    always_comb begin
        w_result = 32'h0;
        case (r_op)
            FOP_ADD,
            FOP_SUB:  w_result = bus.fu_add_result;
            FOP_CONV: w_result = bus.fu_conv_result;
            FOP_RSVD: w_result = 32'h0;
            default:  w_result = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, round-robin history, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= 1'b1;
            r_op        <= FOP_ADD;
            r_id        <= 1'b0;
            r_fuA       <= 32'h0;
            r_fuB       <= 32'h0;
            r_rspValid  <= 1'b0;
            r_rspId     <= 1'b0;
            r_rspData   <= 32'h0;
        end else begin
            if (w_xfer) begin
                r_op        <= w_winOp;
                r_id        <= w_winId;
                r_fuA       <= w_winA;
                r_fuB       <= w_winB;
                r_lastGrant <= w_winId;
            end
            if (w_capture) begin
                r_rspValid <= 1'b1;
                r_rspId    <= r_id;
                r_rspData  <= w_result;
            end else if (w_rspDone) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    assign bus.fu_a       = r_fuA;
    assign bus.fu_b       = r_fuB;
    assign bus.fu_add_en  = r_addEn;
    assign bus.fu_sub     = r_sub;
    assign bus.fu_conv_en = r_convEn;
    assign bus.rsp_valid  = r_rspValid;
    assign bus.rsp_id     = r_rspId;
    assign bus.rsp_data   = r_rspData;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_float_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_arbiter
// Description : Self-checking bench for float_arbiter. Models the two float
//               units (result valid LATENCY cycles after enable), drives
//               directed and random requests and compares grant order,
//               enable duration, response timing and data against a
//               behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_float_arbiter;
    import float_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    float_arbiter_if bus();

    float_arbiter #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nPass  = 0;
    int nTotal = 0;

    // Behavioural reference state: index of the last granted requester.
    int mLast = 1;

    // Per-requester stimulus held by the bench.
    fop_t        s0op, s1op;
    logic [31:0] s0a, s0b, s1a, s1b;

    // ------------------------------------------------------------------
    // Float unit stand-ins: exact IEEE results for the known vectors,
    // arbitrary distinct mappings otherwise (the arbiter only forwards).
    // ------------------------------------------------------------------
    function automatic logic [31:0] unitAdd(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (!sub && a == 32'h41A80000 && b == 32'h420C0000) return 32'h42600000;
        if (sub && a == 32'h447A0000 && b == 32'hC1200000) return 32'h447C8000;
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [31:0] unitConv(input logic [31:0] a);
        if (a == 32'd21) return 32'h41A80000;
        return ~a;
    endfunction

    function automatic logic [31:0] expData(input fop_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return unitAdd(a, b, 1'b0);
            2'd1:    return unitAdd(a, b, 1'b1);
            2'd2:    return unitConv(a);
            default: return 32'h0;
        endcase
    endfunction

    // Unit results are garbage until the enable has been high LATENCY cycles.
    int addCnt  = 0;
    int convCnt = 0;
    always @(posedge clk) begin
        addCnt  <= bus.fu_add_en  ? addCnt + 1  : 0;
        convCnt <= bus.fu_conv_en ? convCnt + 1 : 0;
    end
    always_comb begin
        bus.fu_add_result  = (addCnt >= LAT) ? unitAdd(bus.fu_a, bus.fu_b, bus.fu_sub) : 32'hBAD0BAD0;
        bus.fu_conv_result = (convCnt >= LAT) ? unitConv(bus.fu_a) : 32'hBAD1BAD1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveReqs();
        bus.req0_op = s0op; bus.req0_a = s0a; bus.req0_b = s0b;
        bus.req1_op = s1op; bus.req1_a = s1a; bus.req1_b = s1b;
    endtask

    // One complete operation: present the requests, follow the winner to its
    // response, apply hold cycles of back-pressure and acknowledge.
    task automatic txn(input bit v0, input bit v1, input int hold, input string tag);
        int          win, k, first, enA, enC, subBad, rdyBad, busyBad, stBad;
        fop_t        op;
        logic [31:0] opA, opB, expD;

        bus.req0_valid = v0;
        bus.req1_valid = v1;
        driveReqs();
        win  = (v0 && v1) ? ((mLast == 1) ? 0 : 1) : (v1 ? 1 : 0);
        op   = (win == 1) ? s1op : s0op;
        opA  = (win == 1) ? s1a  : s0a;
        opB  = (win == 1) ? s1b  : s0b;
        expD = expData(op, opA, opB);
        #1;
        k = 0;
        while (!bus.req0_ready && !bus.req1_ready && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_grant"}, 32'({bus.req1_ready, bus.req0_ready}), (win == 1) ? 32'd2 : 32'd1);
        mLast = win;
        tick();
        if (win == 1) bus.req1_valid = 1'b0;
        else          bus.req0_valid = 1'b0;

        first = 0; enA = 0; enC = 0; subBad = 0; rdyBad = 0; busyBad = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.fu_add_en) begin
                enA++;
                if (bus.fu_sub !== (op == FOP_SUB)) subBad++;
            end
            if (bus.fu_conv_en) enC++;
            if (bus.rsp_valid) begin
                first = c;
                break;
            end
            if (bus.req0_ready || bus.req1_ready) rdyBad++;
            if (!bus.busy) busyBad++;
            tick();
        end
        chk({tag, "_rsp_cycle"}, 32'(first), 32'(LAT + 2));
        chk({tag, "_add_en_cycles"}, 32'(enA), usesAdder(op) ? 32'(LAT + 1) : 32'd0);
        chk({tag, "_conv_en_cycles"}, 32'(enC), (op == FOP_CONV) ? 32'(LAT + 1) : 32'd0);
        chk({tag, "_fu_sub"}, 32'(subBad), 32'd0);
        chk({tag, "_ready_while_busy"}, 32'(rdyBad), 32'd0);
        chk({tag, "_busy"}, 32'(busyBad), 32'd0);
        chk({tag, "_fu_a"}, bus.fu_a, opA);
        if (op != FOP_CONV) chk({tag, "_fu_b"}, bus.fu_b, opB);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(win));
        chk({tag, "_rsp_data"}, bus.rsp_data, expD);

        stBad = 0;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== expD || bus.rsp_id !== win[0] ||
                bus.busy !== 1'b1 || bus.req0_ready || bus.req1_ready) stBad++;
        end
        chk({tag, "_rsp_stable"}, 32'(stBad), 32'd0);

        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_no_ready_at_ack"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int bad;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
        s0op = FOP_ADD; s0a = 32'h0; s0b = 32'h0;
        s1op = FOP_ADD; s1a = 32'h0; s1b = 32'h0;
        driveReqs();

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_add_en",  32'(bus.fu_add_en),  32'd0);
        chk("rst_conv_en", 32'(bus.fu_conv_en), 32'd0);
        chk("rst_sub",     32'(bus.fu_sub),     32'd0);
        chk("rst_fu_a",    bus.fu_a,            32'd0);
        chk("rst_fu_b",    bus.fu_b,            32'd0);
        chk("rst_rsp",     32'({bus.rsp_valid, bus.rsp_id}), 32'd0);
        chk("rst_rsp_data", bus.rsp_data,       32'd0);
        chk("rst_busy",    32'(bus.busy),       32'd0);
        chk("rst_ready",   32'({bus.req1_ready, bus.req0_ready}), 32'd0);

        // 21.0 + 35.0 on requester 0
        s0op = FOP_ADD; s0a = 32'h41A80000; s0b = 32'h420C0000;
        txn(1'b1, 1'b0, 0, "fadd");

        // Two ties in a row: req0 first, then req1
        s0op = FOP_ADD;  s0a = 32'h3F800000; s0b = 32'h40000000;
        s1op = FOP_CONV; s1a = 32'd1234;     s1b = 32'h0;
        txn(1'b1, 1'b1, 1, "tie_a");
        s0op = FOP_SUB;  s0a = 32'h40400000; s0b = 32'h3F800000;
        txn(1'b1, 1'b1, 1, "tie_b");

        // Conversion with long back-pressure
        s1op = FOP_CONV; s1a = 32'd21; s1b = 32'hFFFFFFFF;
        txn(1'b0, 1'b1, 10, "fconv");

        // 1000.0 - (-10.0)
        s0op = FOP_SUB; s0a = 32'h447A0000; s0b = 32'hC1200000;
        txn(1'b1, 1'b0, 2, "fsub");

        // Reserved op: no enable, zero data
        s0op = FOP_RSVD; s0a = 32'h12345678; s0b = 32'h9ABCDEF0;
        txn(1'b1, 1'b0, 0, "op3");

        // Reset while a fadd is in WAIT
        s0op = FOP_ADD; s0a = 32'h40A00000; s0b = 32'h40C00000;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
        driveReqs();
        #1;
        chk("abort_grant", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        chk("abort_en_before", 32'(bus.fu_add_en), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mLast = 1;
        chk("abort_en_after", 32'({bus.fu_add_en, bus.fu_conv_en}), 32'd0);
        chk("abort_busy",     32'(bus.busy), 32'd0);
        chk("abort_fu_a",     bus.fu_a,      32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid || bus.fu_add_en || bus.busy) bad++;
            tick();
        end
        chk("abort_no_rsp", 32'(bad), 32'd0);

        // Tie right after reset: requester 0 must win again
        s0op = FOP_CONV; s0a = 32'd77;        s0b = 32'h0;
        s1op = FOP_ADD;  s1a = 32'h11111111;  s1b = 32'h22222222;
        txn(1'b1, 1'b1, 0, "post_rst_tie");

        // Random traffic
        for (int r = 0; r < 10; r++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            s0op = 2'($urandom_range(0, 3)); s0a = $urandom(); s0b = $urandom();
            s1op = 2'($urandom_range(0, 3)); s1a = $urandom(); s1b = $urandom();
            txn(v0, v1, int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float_arbiter.md
FLOAT_ARBITER -- requirements
Module: float_arbiter

Interface
REQ-001 Parameter LATENCY, default 3: cycles from unit enable to valid unit result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_op / req1_op  input  2  0=fadd, 1=fsub, 2=fconv (int to float, a only), 3=reserved.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 req0_ready / req1_ready  output  1  combinational grant; transfer on valid&&ready.
REQ-008 fu_a, fu_b  output  32  registered operands driven to the shared float units.
REQ-009 fu_add_en  output  1  enable for shared FloatingAdd; fu_sub  output  1  subtract select.
REQ-010 fu_conv_en  output  1  enable for FloatingFromInt.
REQ-011 fu_add_result, fu_conv_result  input  32  unit results.
REQ-012 rsp_valid  output  1; rsp_id  output  1 (requester index); rsp_data  output  32; rsp_ready  input  1.
REQ-013 busy  output  1  high in any state except IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; any other encoding SHALL go to IDLE next cycle.
REQ-015 reqN_ready SHALL be high only in IDLE when reqN_valid is high and N is the grant winner.
REQ-016 Grant: only one valid -> that one; both valid -> the one not granted last; last_grant resets to 1, so req0 wins the first tie.
REQ-017 On transfer, latch op, id, a->fu_a, b->fu_b, update last_grant, go to ISSUE.
REQ-018 ISSUE: assert fu_add_en (op 0/1, fu_sub=op[0]) or fu_conv_en (op 2); load counter with LATENCY-1; go to WAIT.
REQ-019 The enable stays high through ISSUE and all of WAIT; it drops on entry to RESP.
REQ-020 WAIT: decrement counter each cycle; at 0, capture fu_add_result (op 0/1) or fu_conv_result (op 2) into rsp_data; go to RESP.
REQ-021 rsp_valid SHALL first be high exactly LATENCY+2 cycles after the transfer edge.
REQ-022 RESP: hold rsp_valid, rsp_id, rsp_data stable until rsp_ready is high; on that edge go to IDLE.
REQ-023 No new request is accepted in the cycle rsp_ready completes; earliest next transfer is the following IDLE cycle.
REQ-024 Op 3: no enable asserted; WAIT is still counted; rsp_data=32'h0.
REQ-025 fu_a and fu_b SHALL hold their values outside transfers; fu_b is don't-care for op 2.
REQ-026 A requester dropping valid before ready SHALL lose its request silently; last_grant is unchanged.
REQ-027 Simultaneous rsp handshake and a new valid: the response completes and the request waits one cycle.

Reset
REQ-028 Reset SHALL force IDLE, last_grant=1, counter=0, fu_add_en=fu_conv_en=fu_sub=0, fu_a=fu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-029 Reset mid-operation SHALL abort the operation: enables drop next cycle and no response is produced.

Structure
REQ-030 Op encodings (FOP_ADD=0, FOP_SUB=1, FOP_CONV=2) and state encodings SHALL be defined in shared package float_pkg; the reader decoder imports the same op constants.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs: two valids, last_grant; output: one-hot grant); everything else stays flat.

Verification
REQ-032 After reset, req0 fadd a=32'h41A80000, b=32'h420C0000, LATENCY=3 -> fu_add_en high 4 cycles, rsp_valid at transfer+5, rsp_id=0, rsp_data=32'h42600000 (21.0+35.0=56.0).
REQ-033 Both valid on the same cycle, twice -> grants req0, then req1; req1 is held off with ready=0 until the first response is acknowledged.
REQ-034 req1 fconv a=32'd21 with rsp_ready held low 10 cycles -> rsp_data=32'h41A80000 stays stable, busy=1 throughout, no ready asserted.
REQ-035 req0 fsub a=32'h447A0000 (1000.0), b=32'hC1200000 (-10.0) -> fu_sub=1, rsp_data=32'h447C8000 (1010.0).
REQ-036 Op 3 request -> no enable pulse, rsp_data=0 at transfer+5; reset asserted in WAIT of a following fadd -> rsp_valid never rises, enables drop.
